// File: rtl/i2c_read_arbiter.sv
// rtl/i2c_read_arbiter.sv - round-robin arbiter sharing one byte-read I2C master among NREQ requesters
// Optional watchdog abort is built when I2C_ARB_TIMEOUT_EN is defined.

module i2c_read_arbiter #(
  parameter int NREQ           = 2,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [7*NREQ-1:0] req_sadr,
  input  logic [8*NREQ-1:0] req_wadr,
  input  logic [8*NREQ-1:0] req_len,
  output logic [NREQ-1:0]   req_ready,
  output logic [7:0]        rsp_data,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [NREQ-1:0]   rsp_done,
  output logic [NREQ-1:0]   rsp_err,
  output logic              m_start,
  output logic [6:0]        m_sadr,
  output logic [7:0]        m_wadr,
  output logic [7:0]        m_len,
  output logic              m_abort,
  input  logic [7:0]        m_rdata,
  input  logic              m_rvalid,
  input  logic              m_done,
  input  logic              m_nack
);

  localparam int              GW       = $clog2(NREQ);
  localparam logic [GW:0]     NREQ_W   = (GW+1)'(NREQ);
  localparam logic [GW-1:0]   LAST_RST = GW'(NREQ-1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   gnt, last, win;
  logic [GW:0]     idx;
  logic            found;
  logic            err;
  logic            timeout;
  logic [NREQ-1:0] gnt_oh;

  assign gnt_oh = {{(NREQ-1){1'b0}}, 1'b1} << gnt;

  // Search order starts just after the previous owner, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = {1'b0, last} + (GW+1)'(k);
      if (idx >= NREQ_W) idx = idx - NREQ_W;
      if (!found && req_valid[idx[GW-1:0]]) begin
        found = 1'b1;
        win   = idx[GW-1:0];
      end
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wd_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            wd_cnt <= '0;
    else if (state == ISSUE) wd_cnt <= '0;
    else if (state == WAIT)  wd_cnt <= wd_cnt + CW'(1);
  end

  // A completion arriving in the expiry cycle wins over the abort.
  assign timeout = (state == WAIT) && (wd_cnt == CW'(TIMEOUT_CYCLES)) && !m_done;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout        = 1'b0;
`endif

  assign m_abort = timeout;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    m_start   = 1'b0;
    req_ready = '0;
    rsp_done  = '0;
    rsp_err   = '0;
    case (state)
      IDLE: begin
        if (found) state_nxt = ISSUE;
      end
      ISSUE: begin
        m_start   = 1'b1;
        req_ready = gnt_oh;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (m_done || timeout) state_nxt = DONE;
      end
      DONE: begin
        rsp_done  = gnt_oh;
        rsp_err   = err ? gnt_oh : '0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt       <= '0;
      last      <= LAST_RST;
      err       <= 1'b0;
      m_sadr    <= '0;
      m_wadr    <= '0;
      m_len     <= '0;
      rsp_data  <= '0;
      rsp_valid <= '0;
    end else begin
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            gnt    <= win;
            m_sadr <= req_sadr[7*win +: 7];
            m_wadr <= req_wadr[8*win +: 8];
            m_len  <= req_len[8*win +: 8];
          end
        end
        ISSUE: err <= 1'b0;
        WAIT: begin
          // Bytes and completion are only honoured while a transaction is owned.
          if (m_rvalid) begin
            rsp_valid <= gnt_oh;
            rsp_data  <= m_rdata;
          end
          if (m_done)       err <= m_nack;
          else if (timeout) err <= 1'b1;
        end
        DONE: last <= gnt;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_read_arbiter.sv
// tb/tb_i2c_read_arbiter.sv - randomized self-checking bench for i2c_read_arbiter

module tb_i2c_read_arbiter;

  localparam int NREQ = 2;
  localparam int TO   = 100;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [7*NREQ-1:0] req_sadr;
  logic [8*NREQ-1:0] req_wadr;
  logic [8*NREQ-1:0] req_len;
  logic [NREQ-1:0]   req_ready;
  logic [7:0]        rsp_data;
  logic [NREQ-1:0]   rsp_valid, rsp_done, rsp_err;
  logic              m_start, m_abort;
  logic [6:0]        m_sadr;
  logic [7:0]        m_wadr, m_len;
  logic [7:0]        m_rdata = '0;
  logic              m_rvalid = 1'b0, m_done = 1'b0, m_nack = 1'b0;

  logic [6:0] sadr [NREQ];
  logic [7:0] wadr [NREQ];
  logic [7:0] len  [NREQ];

  for (genvar r = 0; r < NREQ; r++) begin : g_pack
    assign req_sadr[7*r +: 7] = sadr[r];
    assign req_wadr[8*r +: 8] = wadr[r];
    assign req_len[8*r +: 8]  = len[r];
  end

  i2c_read_arbiter #(.NREQ(NREQ), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_sadr(req_sadr), .req_wadr(req_wadr), .req_len(req_len),
    .req_ready(req_ready), .rsp_data(rsp_data), .rsp_valid(rsp_valid),
    .rsp_done(rsp_done), .rsp_err(rsp_err),
    .m_start(m_start), .m_sadr(m_sadr), .m_wadr(m_wadr), .m_len(m_len), .m_abort(m_abort),
    .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_done(m_done), .m_nack(m_nack)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int last_g = NREQ - 1;

  // Expected response outputs for the next sampling point.
  logic [NREQ-1:0] e_vld = '0, e_done = '0, e_err = '0;
  logic [7:0]      e_data = '0;
  logic            e_abort = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NREQ-1:0] oh(input int g);
    logic [NREQ-1:0] v;
    v = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++)
      if (v[(last_g + k) % NREQ]) return (last_g + k) % NREQ;
    return 0;
  endfunction

  task automatic step();
    @(negedge clk);
    check("rsp_valid", rsp_valid, e_vld);
    if (e_vld != '0) check("rsp_data", rsp_data, e_data);
    check("rsp_done", rsp_done, e_done);
    check("rsp_err", rsp_err, e_err);
    check("m_abort", m_abort, e_abort);
    e_vld = '0; e_done = '0; e_err = '0; e_abort = 1'b0;
    m_rvalid = 1'b0; m_done = 1'b0; m_nack = 1'b0;
  endtask

  task automatic randomize_fields();
    for (int r = 0; r < NREQ; r++) begin
      sadr[r] = 7'($urandom);
      wadr[r] = 8'($urandom);
      len[r]  = 8'($urandom);
    end
  endtask

  task automatic launch(input int exp_lat, input bit keep, output int g);
    int lat = 0;
    g = rr_pick(req_valid);
    while (lat < 20) begin
      step();
      lat++;
      if (m_start) break;
      check("req_ready_quiet", req_ready, '0);
    end
    check("start_latency", lat, exp_lat);
    check("req_ready", req_ready, oh(g));
    check("m_sadr", m_sadr, sadr[g]);
    check("m_wadr", m_wadr, wadr[g]);
    check("m_len", m_len, len[g]);
    if (!keep) req_valid = '0;
    // Strobes during ISSUE fall outside WAIT and must be dropped.
    m_rvalid = 1'b1; m_rdata = 8'($urandom); m_done = 1'b1; m_nack = 1'($urandom);
    step();
    check("m_start_pulse", m_start, 1'b0);
    check("req_ready_pulse", req_ready, '0);
  endtask

  task automatic serve(input int g, input int nbytes, input bit nack, input bit together,
                       input bit rnd, input logic [7:0] base);
    for (int i = 0; i < nbytes; i++) begin
      repeat ($urandom_range(0, 2)) step();
      m_rvalid = 1'b1;
      m_rdata  = rnd ? 8'($urandom) : base + 8'(i);
      e_vld    = oh(g);
      e_data   = m_rdata;
      if (together && i == nbytes - 1) begin
        m_done = 1'b1; m_nack = nack;
        e_done = oh(g); e_err = nack ? oh(g) : '0;
      end
      step();
    end
    if (!together || nbytes == 0) begin
      repeat ($urandom_range(0, 2)) step();
      m_done = 1'b1; m_nack = nack;
      e_done = oh(g); e_err = nack ? oh(g) : '0;
      step();
    end
    last_g = g;
    m_rvalid = 1'b1; m_rdata = 8'($urandom); m_done = 1'b1; m_nack = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int g;
    for (int r = 0; r < NREQ; r++) begin sadr[r] = '0; wadr[r] = '0; len[r] = '0; end
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, '0);
    check("rst_rsp_valid", rsp_valid, '0);
    check("rst_rsp_done", rsp_done, '0);
    check("rst_rsp_err", rsp_err, '0);
    check("rst_rsp_data", rsp_data, '0);
    check("rst_m_start", m_start, 1'b0);
    check("rst_m_abort", m_abort, 1'b0);
    check("rst_m_sadr", m_sadr, '0);
    reset_n = 1'b1;
    step();

    // Contention: all requesters held valid, grants must rotate.
    randomize_fields();
    req_valid = '1;
    for (int i = 0; i < 3 * NREQ; i++) begin
      launch(i == 0 ? 1 : 2, 1'b1, g);
      check("rr_order", g, i % NREQ);
      serve(g, $urandom_range(0, 3), 1'($urandom), 1'($urandom), 1'b1, 8'h00);
    end
    req_valid = '0;
    step();

    // Single request with known data.
    sadr[0] = 7'h53; wadr[0] = 8'h00; len[0] = 8'd4;
    req_valid = 2'b01;
    launch(1, 1'b0, g);
    serve(g, 4, 1'b0, 1'b0, 1'b0, 8'hA0);
    step();

    // NACK with no data.
    req_valid = 2'b10;
    launch(1, 1'b0, g);
    serve(g, 0, 1'b1, 1'b0, 1'b1, 8'h00);
    step();

    // Last byte and done in the same cycle.
    req_valid = 2'b01;
    launch(1, 1'b0, g);
    serve(g, 1, 1'b0, 1'b1, 1'b0, 8'h5A);
    step();

    for (int t = 0; t < 20; t++) begin
      randomize_fields();
      req_valid = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      launch(1, 1'b0, g);
      serve(g, $urandom_range(0, 5), 1'($urandom), 1'($urandom), 1'b1, 8'h00);
      step();
    end

    // Reset in the middle of a read.
    len[0] = 8'd8;
    req_valid = 2'b01;
    launch(1, 1'b0, g);
    for (int i = 0; i < 2; i++) begin
      m_rvalid = 1'b1; m_rdata = 8'($urandom);
      e_vld = oh(g); e_data = m_rdata;
      step();
    end
    reset_n = 1'b0;
    #1;
    check("mid_rst_rsp_valid", rsp_valid, '0);
    check("mid_rst_rsp_data", rsp_data, '0);
    check("mid_rst_rsp_done", rsp_done, '0);
    check("mid_rst_m_sadr", m_sadr, '0);
    check("mid_rst_m_len", m_len, '0);
    check("mid_rst_m_start", m_start, 1'b0);
    check("mid_rst_req_ready", req_ready, '0);
    step();
    step();
    reset_n = 1'b1;
    last_g = NREQ - 1;
    step();
    randomize_fields();
    req_valid = '1;
    launch(1, 1'b0, g);
    check("post_rst_winner", g, 0);
    serve(g, 2, 1'b0, 1'b0, 1'b1, 8'h00);
    step();

`ifdef I2C_ARB_TIMEOUT_EN
    // Master never completes: watchdog must abort after TO cycles in WAIT.
    req_valid = 2'b10;
    launch(1, 1'b0, g);
    for (int i = 1; i <= TO; i++) begin
      if (i == TO) e_abort = 1'b1;
      step();
    end
    e_done = oh(g); e_err = oh(g);
    step();
    last_g = g;
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
